// File: rtl/wb_retire_queue_pkg.sv
// Shared types and default sizing for the writeback retire queue.
package wb_stage_params;

    localparam int unsigned WB_DATA_WIDTH  = 32;
    localparam int unsigned WB_ADDR_WIDTH  = 5;
    localparam int unsigned WB_PC_WIDTH    = 32;
    localparam int unsigned WB_QUEUE_DEPTH = 2;
    localparam int unsigned WB_STRB_WIDTH  = WB_DATA_WIDTH / 8;

    typedef struct packed {
        logic [WB_PC_WIDTH-1:0]   program_count;
        logic [WB_STRB_WIDTH-1:0] write_strobe;
        logic [WB_ADDR_WIDTH-1:0] write_address;
        logic [WB_DATA_WIDTH-1:0] write_data;
    } WBQueueEntry;

    typedef struct packed {
        logic                     hit;
        logic                     busy;
        logic [WB_DATA_WIDTH-1:0] data;
    } WBForwardResult;

endpackage

// File: rtl/wb_retire_queue_if.sv
// IO-stage to writeback handshake: the IO stage is master, the queue is slave.
interface wb_retire_queue_if
    import wb_stage_params::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned PC_WIDTH   = WB_PC_WIDTH
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  io_valid;
    logic                  wb_allow_in;
    logic [PC_WIDTH-1:0]   io_program_count;
    logic [STRB_WIDTH-1:0] io_write_strobe;
    logic [ADDR_WIDTH-1:0] io_write_address;
    logic [DATA_WIDTH-1:0] io_write_data;

    modport master (
        output io_valid, io_program_count, io_write_strobe, io_write_address, io_write_data,
        input  wb_allow_in
    );

    modport slave (
        input  io_valid, io_program_count, io_write_strobe, io_write_address, io_write_data,
        output wb_allow_in
    );

endinterface

// File: rtl/wb_retire_queue_forward.sv
// Youngest-first register match across the queued entries for ID-stage forwarding.
module wb_forward_lookup #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned PTR_WIDTH  = 1
) (
    input  logic [ADDR_WIDTH-1:0]   entry_address [DEPTH],
    input  logic [DATA_WIDTH/8-1:0] entry_strobe  [DEPTH],
    input  logic [DATA_WIDTH-1:0]   entry_data    [DEPTH],
    input  logic [DEPTH-1:0]        valid,
    input  logic [PTR_WIDTH-1:0]    tail,
    input  logic [ADDR_WIDTH-1:0]   query_address,
    output logic                    hit,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   data
);

    logic                 found;
    logic [PTR_WIDTH-1:0] idx;

    // k=0 is the slot just behind tail, i.e. the youngest entry.
    always_comb begin
        hit   = 1'b0;
        busy  = 1'b0;
        data  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = PTR_WIDTH'((32'(tail) + DEPTH - 1 - k) % DEPTH);
            if (!found && valid[idx] && query_address != '0 &&
                entry_address[idx] == query_address && entry_strobe[idx] != '0) begin
                found = 1'b1;
                if (&entry_strobe[idx]) begin
                    hit  = 1'b1;
                    data = entry_data[idx];
                end else begin
                    busy = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers completed instructions until the register-file port is granted.
module wb_retire_queue
    import wb_stage_params::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned PC_WIDTH   = WB_PC_WIDTH,
    parameter int unsigned DEPTH      = WB_QUEUE_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    wb_retire_queue_if.slave          io,
    input  logic                      rf_write_ready,
    output logic                      rf_write_enabled,
    output logic [DATA_WIDTH/8-1:0]   rf_write_strobe,
    output logic [ADDR_WIDTH-1:0]     rf_write_address,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    input  logic [ADDR_WIDTH-1:0]     id_query_address,
    output logic                      id_forward_hit,
    output logic [DATA_WIDTH-1:0]     id_forward_data,
    output logic                      id_forward_busy,
    output logic [31:0]               retire_count,
    output logic [PC_WIDTH-1:0]       debug_program_count,
    output logic [DATA_WIDTH/8-1:0]   debug_register_file_write_enabled,
    output logic [ADDR_WIDTH-1:0]     debug_register_file_write_address,
    output logic [DATA_WIDTH-1:0]     debug_register_file_write_data
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0]   LAST_SLOT = PTR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL      = COUNT_WIDTH'(DEPTH);

    logic [PC_WIDTH-1:0]   entry_pc      [DEPTH];
    logic [STRB_WIDTH-1:0] entry_strobe  [DEPTH];
    logic [ADDR_WIDTH-1:0] entry_address [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data    [DEPTH];

    logic [PTR_WIDTH-1:0]   head, tail;
    logic [COUNT_WIDTH-1:0] count;
    logic [DEPTH-1:0]       valid;
    logic                   occupied, head_writes, push, pop;
    logic [STRB_WIDTH-1:0]  push_strobe;

    assign occupied       = count != '0;
    assign head_writes    = entry_strobe[head] != '0;
    assign pop            = occupied && (!head_writes || rf_write_ready);
    assign io.wb_allow_in = (count < FULL) || pop;
    assign push           = io.io_valid && io.wb_allow_in;
    // $0 is hardwired: squash the strobe so the entry retires without writing.
    assign push_strobe    = (io.io_write_address == '0) ? '0 : io.io_write_strobe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            retire_count <= '0;
        end else begin
            if (push) tail <= (tail == LAST_SLOT) ? '0 : tail + PTR_WIDTH'(1);
            if (pop)  head <= (head == LAST_SLOT) ? '0 : head + PTR_WIDTH'(1);
            if (push && !pop)      count <= count + COUNT_WIDTH'(1);
            else if (pop && !push) count <= count - COUNT_WIDTH'(1);
            if (pop) retire_count <= retire_count + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entry_pc[tail]      <= io.io_program_count;
            entry_strobe[tail]  <= push_strobe;
            entry_address[tail] <= io.io_write_address;
            entry_data[tail]    <= io.io_write_data;
        end
    end

    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = ((i + DEPTH - 32'(head)) % DEPTH) < 32'(count);
        end
    end

    assign rf_write_enabled = occupied && head_writes && rf_write_ready;
    assign rf_write_strobe  = rf_write_enabled ? entry_strobe[head] : '0;
    assign rf_write_address = occupied ? entry_address[head] : '0;
    assign rf_write_data    = occupied ? entry_data[head] : '0;

    assign debug_program_count               = pop ? entry_pc[head] : '0;
    assign debug_register_file_write_enabled = pop ? rf_write_strobe : '0;
    assign debug_register_file_write_address = pop ? entry_address[head] : '0;
    assign debug_register_file_write_data    = pop ? entry_data[head] : '0;

    wb_forward_lookup #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_forward (
        .entry_address (entry_address),
        .entry_strobe  (entry_strobe),
        .entry_data    (entry_data),
        .valid         (valid),
        .tail          (tail),
        .query_address (id_query_address),
        .hit           (id_forward_hit),
        .busy          (id_forward_busy),
        .data          (id_forward_data)
    );

endmodule

// File: doc/wb_retire_queue.md
Name: wb_retire_queue

Overview:
- Parametrised writeback stage for the MIPS core; sits between the IO stage and the register file / trace interface.
- Buffers up to DEPTH completed instructions so IO-stage flow continues while the register-file write port is withheld (shared with a future multiplier/CP0 writer).
- Adds byte-strobe partial writes (LWL/LWR), a youngest-match forwarding lookup for ID, and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, register data width; must be a multiple of 8
ADDR_WIDTH, 5, register address width
PC_WIDTH, 32, program-count width
DEPTH, 2, queue entries; >=1, need not be a power of two
STRB_WIDTH, DATA_WIDTH/8, derived; not overridden

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high
io_valid  in  1  IO stage offers an instruction
wb_allow_in  out  1  queue accepts this cycle
io_program_count  in  PC_WIDTH  instruction PC
io_write_strobe  in  STRB_WIDTH  byte enables; 0 = no register write
io_write_address  in  ADDR_WIDTH  destination register
io_write_data  in  DATA_WIDTH  result
rf_write_ready  in  1  register-file port granted this cycle
rf_write_enabled  out  1  register-file write strobe
rf_write_strobe  out  STRB_WIDTH  byte enables to register file
rf_write_address  out  ADDR_WIDTH
rf_write_data  out  DATA_WIDTH
id_query_address  in  ADDR_WIDTH  ID source register lookup
id_forward_hit  out  1  full-word match found
id_forward_data  out  DATA_WIDTH  forwarded value
id_forward_busy  out  1  youngest match is a partial write; ID stalls
retire_count  out  32  retired instructions, wraps
debug_program_count  out  PC_WIDTH
debug_register_file_write_enabled  out  STRB_WIDTH
debug_register_file_write_address  out  ADDR_WIDTH
debug_register_file_write_data  out  DATA_WIDTH

Behaviour:
- Circular buffer: head/tail pointers wrap explicitly at DEPTH-1; count is $clog2(DEPTH+1) bits.
- Async reset: pointers, count and retire_count clear to 0. All outputs are 0 in reset except wb_allow_in=1. Entry payload is not reset.
- push = io_valid && wb_allow_in. Entry strobe is forced to 0 when io_write_address==0, so $0 is never written.
- pop = count>0 && (head strobe==0 || rf_write_ready).
- wb_allow_in = count<DEPTH || pop. A push into a full queue is allowed in the same cycle the head pops; count is unchanged.
- Latency: an entry pushed at edge N is at the head from cycle N+1. If the queue was empty and rf_write_ready=1, it retires during cycle N+1.
- rf_write_enabled = count>0 && head strobe!=0 && rf_write_ready.
- rf_write_strobe, rf_write_address and rf_write_data carry the head fields; strobe is gated to 0 when rf_write_enabled=0.
- Empty queue: rf_write_enabled=0 and no pop. Entries with strobe==0 retire regardless of rf_write_ready.
- Forwarding: scan valid entries from youngest to oldest for address==id_query_address with strobe!=0. Query address 0 never matches.
  - Youngest match has full strobe: hit=1, data=entry data, busy=0.
  - Youngest match has partial strobe: hit=0, busy=1.
  - No match: hit=0, busy=0, data=0.
  - Purely combinational on the current queue contents. The entry being popped this cycle still counts.
- retire_count increments by 1 on every pop and wraps 0xFFFFFFFF->0.
- Debug outputs:
  - On a pop cycle: head PC, the rf strobe, head address and head data. A pop with strobe 0 shows enabled=0 and still shows the PC.
  - On a non-pop cycle: all debug outputs are 0.
- Reset asserted mid-operation discards all queued entries immediately; no rf write occurs while reset is high.

Decomposition:
- Shared package wb_stage_params:
  - typedef WBQueueEntry {program_count, write_strobe, write_address, write_data}
  - constant WB_QUEUE_DEPTH default
  - typedef WBForwardResult {hit, busy, data}
- One natural sub-module, wb_forward_lookup: the combinational youngest-first match across DEPTH entries, given the entry array, the valid mask and the tail pointer.

Test Plan:
- Reset released, io_valid=1, pc=0xBFC00000, addr=8, strobe=0xF, data=0x1234, rf_write_ready=1 -> next cycle rf_write_enabled=1, addr 8, data 0x1234, debug pc 0xBFC00000, retire_count=1.
- DEPTH=2, rf_write_ready=0, push writes to r3 then r4 -> wb_allow_in=0. Raise rf_write_ready with a third push offered -> r3 retires and the third push is accepted in the same cycle; count stays 2.
- Queue holds r5=0xAAAA (strobe 0xF) older and r5 strobe 0x3 younger; query 5 -> busy=1, hit=0. After the younger entry retires -> no match, busy=0. Older-only case: hit=1, data=0xAAAA.
- Push to r0 with strobe 0xF, data 0xDEAD -> rf_write_enabled stays 0, debug pc valid, retire_count increments; query 0 -> hit=0.
- Entry with strobe 0 while rf_write_ready=0 -> still pops next cycle; the following writing entry waits for rf_write_ready.
- Assert reset asynchronously between edges with 2 entries queued -> outputs zero immediately, wb_allow_in=1, retire_count=0, nothing written after release.
